// File: rtl/agc_pkg.sv
// Shared AGC definitions: control states, gain fixed-point format and 18-bit saturation.
package agc_pkg;

    typedef enum logic {ACQUIRE, TRACK} agc_state_e;

    localparam int GAIN_FRAC = 14;
    localparam int GAIN_ONE  = 16384;

    // Callers sign-extend their wide intermediate into 48 bits before saturating.
    function automatic logic signed [17:0] sat18(input logic signed [47:0] x);
        if (x > 48'sd131071) begin
            return 18'sd131071;
        end else if (x < -48'sd131072) begin
            return -18'sd131072;
        end else begin
            return x[17:0];
        end
    endfunction

endpackage

// File: rtl/agc_mag_meter.sv
// Mean |sample| over 2^WINDOW_LOG2 symbol strobes; mean/window_done are valid on the closing strobe.
module agc_mag_meter
    import agc_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_clk_ena,
    input  logic signed [17:0] sample,
    output logic        [17:0] mean,
    output logic               window_done,
    output logic        [17:0] mag_est
);

    localparam int AW = 18 + WINDOW_LOG2;

    logic [17:0]            abs_val;
    logic [AW-1:0]          acc_q;
    logic [AW-1:0]          acc_sum;
    logic [WINDOW_LOG2-1:0] sym_cnt_q;

    always_comb begin
        abs_val = 18'(sample);
        if (sample == -18'sd131072) begin
            abs_val = 18'd131071;
        end else if (sample[17]) begin
            abs_val = 18'(-sample);
        end
        acc_sum     = acc_q + AW'(abs_val);
        mean        = acc_sum[AW-1:WINDOW_LOG2];
        window_done = sym_clk_ena && (sym_cnt_q == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            sym_cnt_q <= '0;
            mag_est   <= '0;
        end else if (sym_clk_ena) begin
            sym_cnt_q <= sym_cnt_q + 1'b1;
            if (window_done) begin
                acc_q   <= '0;
                mag_est <= mean;
            end else begin
                acc_q <= acc_sum;
            end
        end
    end

endmodule

// File: rtl/rx_agc.sv
// Receive AGC: multiplicative gain on the sample stream, adapted once per measurement window.
module rx_agc
    import agc_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8,
    parameter int TARGET_MAG  = 32768,
    parameter int DEADBAND    = 1024,
    parameter int STEP_FAST   = 3,
    parameter int STEP_SLOW   = 6,
    parameter int LOCK_COUNT  = 3,
    parameter int GAIN_MIN    = 1024,
    parameter int GAIN_MAX    = 262143
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_ena,
    input  logic               sym_clk_ena,
    input  logic               agc_en,
    input  logic signed [17:0] sig_in,
    output logic signed [17:0] sig_out,
    output logic        [17:0] gain_out,
    output logic        [17:0] mag_est,
    output logic               locked
);

    localparam logic [17:0] HI_TH  = 18'(TARGET_MAG + DEADBAND);
    localparam logic [17:0] LO_TH  = 18'(TARGET_MAG - DEADBAND);
    localparam logic [18:0] G_MIN  = 19'(GAIN_MIN);
    localparam logic [18:0] G_MAX  = 19'(GAIN_MAX);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0]  LOSE_N = 4'd2;

    agc_state_e state_q, state_d;
    logic [3:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [17:0] gain_q, gain_d;

    logic signed [36:0] product;
    logic signed [47:0] product_ext;
    logic [17:0] mean;
    logic        window_done;
    logic        too_high, too_low, in_band;
    logic [17:0] step;
    logic [18:0] gain_raw;

    // Gain is unsigned; a zero MSB makes the signed multiply treat it as positive.
    always_comb begin
        product     = sig_in * $signed({1'b0, gain_q});
        product_ext = product;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_out <= '0;
        end else if (sam_clk_ena) begin
            sig_out <= sat18(product_ext >>> GAIN_FRAC);
        end
    end

    agc_mag_meter #(
        .WINDOW_LOG2(WINDOW_LOG2)
    ) u_mag_meter (
        .clk        (clk),
        .reset      (reset),
        .sym_clk_ena(sym_clk_ena),
        .sample     (sig_out),
        .mean       (mean),
        .window_done(window_done),
        .mag_est    (mag_est)
    );

    always_comb begin
        too_high = mean > HI_TH;
        too_low  = mean < LO_TH;
        in_band  = !too_high && !too_low;
        step     = (state_q == TRACK) ? (gain_q >> STEP_SLOW) : (gain_q >> STEP_FAST);

        gain_raw = {1'b0, gain_q};
        if (too_high) begin
            gain_raw = {1'b0, gain_q} - {1'b0, step};
        end else if (too_low) begin
            gain_raw = {1'b0, gain_q} + {1'b0, step};
        end

        gain_d = gain_q;
        if (agc_en && window_done) begin
            if (gain_raw > G_MAX) begin
                gain_d = G_MAX[17:0];
            end else if (gain_raw < G_MIN) begin
                gain_d = G_MIN[17:0];
            end else begin
                gain_d = gain_raw[17:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (!agc_en) begin
            state_d   = ACQUIRE;
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end else if (window_done) begin
            case (state_q)
                ACQUIRE: begin
                    out_cnt_d = '0;
                    if (!in_band) begin
                        in_cnt_d = '0;
                    end else if (in_cnt_q + 4'd1 >= LOCK_N) begin
                        state_d  = TRACK;
                        in_cnt_d = '0;
                    end else begin
                        in_cnt_d = in_cnt_q + 4'd1;
                    end
                end
                TRACK: begin
                    in_cnt_d = '0;
                    if (in_band) begin
                        out_cnt_d = '0;
                    end else if (out_cnt_q + 4'd1 >= LOSE_N) begin
                        state_d   = ACQUIRE;
                        out_cnt_d = '0;
                    end else begin
                        out_cnt_d = out_cnt_q + 4'd1;
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end
        locked = (state_q == TRACK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ACQUIRE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            gain_q    <= 18'(GAIN_ONE);
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            gain_q    <= gain_d;
        end
    end

    assign gain_out = gain_q;

endmodule

// File: tb/tb_rx_agc.sv
// Directed bench for rx_agc: 16-symbol windows, two samples per symbol, expected values precomputed.
module tb_rx_agc;

    logic               clk = 1'b0;
    logic               reset;
    logic               sam_clk_ena;
    logic               sym_clk_ena;
    logic               agc_en;
    logic signed [17:0] sig_in;
    logic signed [17:0] sig_out;
    logic        [17:0] gain_out;
    logic        [17:0] mag_est;
    logic               locked;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Floor raised to 8192: a full-scale 1s17 input cannot push the mean out of band below ~4224.
    rx_agc #(
        .WINDOW_LOG2(4),
        .GAIN_MIN   (8192)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sam_clk_ena(sam_clk_ena),
        .sym_clk_ena(sym_clk_ena),
        .agc_en     (agc_en),
        .sig_in     (sig_in),
        .sig_out    (sig_out),
        .gain_out   (gain_out),
        .mag_est    (mag_est),
        .locked     (locked)
    );

    typedef struct {
        bit rst;
        int amp;
        bit alt;
        bit en;
        int mag;
        int gain;
        int sig;
        bit lock;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sample on the first cycle, sample+symbol strobe on the third; inputs change on negedges.
    task automatic send_symbol(input int v);
        @(negedge clk);
        sig_in      = v[17:0];
        sam_clk_ena = 1'b1;
        sym_clk_ena = 1'b0;
        @(negedge clk);
        sam_clk_ena = 1'b0;
        @(negedge clk);
        sam_clk_ena = 1'b1;
        sym_clk_ena = 1'b1;
        @(negedge clk);
        sam_clk_ena = 1'b0;
        sym_clk_ena = 1'b0;
    endtask

    task automatic run_window(input int amp, input bit alt);
        for (int s = 0; s < 16; s++) begin
            send_symbol((alt && s[0]) ? -amp : amp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset       = 1'b1;
        sam_clk_ena = 1'b0;
        sym_clk_ena = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit reached;

        // Gain ramp from 16384 with +/-16384 input (sig_out magnitude equals gain), then lock.
        vecs[0]  = '{1'b1, 16384, 1'b1, 1'b1, 16384, 18432, -16384, 1'b0};
        vecs[1]  = '{1'b0, 16384, 1'b1, 1'b1, 18432, 20736, -18432, 1'b0};
        vecs[2]  = '{1'b0, 16384, 1'b1, 1'b1, 20736, 23328, -20736, 1'b0};
        vecs[3]  = '{1'b0, 16384, 1'b1, 1'b1, 23328, 26244, -23328, 1'b0};
        vecs[4]  = '{1'b0, 16384, 1'b1, 1'b1, 26244, 29524, -26244, 1'b0};
        vecs[5]  = '{1'b0, 16384, 1'b1, 1'b1, 29524, 33214, -29524, 1'b0};
        vecs[6]  = '{1'b0, 16384, 1'b1, 1'b1, 33214, 33214, -33214, 1'b0};
        vecs[7]  = '{1'b0, 16384, 1'b1, 1'b1, 33214, 33214, -33214, 1'b0};
        vecs[8]  = '{1'b0, 16384, 1'b1, 1'b1, 33214, 33214, -33214, 1'b1};
        // Amplitude x4 while tracking: slow step, slow step + unlock, then fast step.
        vecs[9]  = '{1'b0, 65536, 1'b1, 1'b1, 131071, 32696, -131072, 1'b1};
        vecs[10] = '{1'b0, 65536, 1'b1, 1'b1, 130784, 32186, -130784, 1'b0};
        vecs[11] = '{1'b0, 65536, 1'b1, 1'b1, 128744, 28163, -128744, 1'b0};
        // Full-scale negative input: abs saturation, gain walked down onto the floor.
        vecs[12] = '{1'b1, -131072, 1'b0, 1'b1, 131071, 14336, -131072, 1'b0};
        vecs[13] = '{1'b0, -131072, 1'b0, 1'b1, 114688, 12544, -114688, 1'b0};
        vecs[14] = '{1'b0, -131072, 1'b0, 1'b1, 100352, 10976, -100352, 1'b0};
        vecs[15] = '{1'b0, -131072, 1'b0, 1'b1, 87808, 9604, -87808, 1'b0};
        vecs[16] = '{1'b0, -131072, 1'b0, 1'b1, 76832, 8404, -76832, 1'b0};
        vecs[17] = '{1'b0, -131072, 1'b0, 1'b1, 67232, 8192, -67232, 1'b0};
        vecs[18] = '{1'b0, -131072, 1'b0, 1'b1, 65536, 8192, -65536, 1'b0};
        // Adaptation disabled: gain frozen, measurement continues; re-enable corrects.
        vecs[19] = '{1'b1, 16384, 1'b1, 1'b0, 16384, 16384, -16384, 1'b0};
        vecs[20] = '{1'b0, 16384, 1'b1, 1'b0, 16384, 16384, -16384, 1'b0};
        vecs[21] = '{1'b0, 16384, 1'b1, 1'b1, 16384, 18432, -16384, 1'b0};

        reset       = 1'b1;
        sam_clk_ena = 1'b0;
        sym_clk_ena = 1'b0;
        agc_en      = 1'b1;
        sig_in      = '0;
        repeat (2) @(negedge clk);
        check("rst sig_out", int'(sig_out), 0);
        check("rst gain", int'(gain_out), 16384);
        check("rst mag", int'(mag_est), 0);
        check("rst locked", int'(locked), 0);
        reset = 1'b0;

        // Reset mid-window, then confirm the first window after release is full length.
        for (int s = 0; s < 16; s++) send_symbol(32768);
        check("pre mag", int'(mag_est), 32768);
        check("pre sig_out", int'(sig_out), 32768);
        for (int s = 0; s < 5; s++) send_symbol(32768);
        #2 reset = 1'b1;
        #1;
        check("midrst sig_out", int'(sig_out), 0);
        check("midrst gain", int'(gain_out), 16384);
        check("midrst mag", int'(mag_est), 0);
        check("midrst locked", int'(locked), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 15; s++) send_symbol(32768);
        check("postrst mag early", int'(mag_est), 0);
        send_symbol(32768);
        check("postrst mag", int'(mag_est), 32768);
        check("postrst gain", int'(gain_out), 16384);

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].rst) apply_reset();
            agc_en = vecs[i].en;
            run_window(vecs[i].amp, vecs[i].alt);
            check($sformatf("v%0d mag", i), int'(mag_est), vecs[i].mag);
            check($sformatf("v%0d gain", i), int'(gain_out), vecs[i].gain);
            check($sformatf("v%0d sig_out", i), int'(sig_out), vecs[i].sig);
            check($sformatf("v%0d locked", i), int'(locked), int'(vecs[i].lock));
        end

        // Small input drives the gain up to the ceiling, where it must stay.
        apply_reset();
        agc_en  = 1'b1;
        reached = 1'b0;
        for (int w = 0; w < 40 && !reached; w++) begin
            run_window(64, 1'b0);
            if (gain_out == 18'd262143) reached = 1'b1;
        end
        check("ceil reached", int'(reached), 1);
        run_window(64, 1'b0);
        check("ceil gain", int'(gain_out), 262143);
        check("ceil mag", int'(mag_est), 1023);
        check("ceil sig_out", int'(sig_out), 1023);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_agc.md
Name: rx_agc

Overview:
- Receive-side automatic gain control at the channel output.
- Removes the unknown channel gain (gain_set, 1/2/4/8x) and normalizes the received 1s17 sample stream to a fixed mean magnitude before the matched filter and slicer.
- Measures mean |sig_out| over a window of symbol strobes and adjusts a multiplicative gain: fast acquisition, then slow tracking with a lock indicator.

Parameters:
- WINDOW_LOG2, 8: log2 of symbols per measurement window.
- TARGET_MAG, 32768: required mean |sig_out| (0.25 in 1s17).
- DEADBAND, 1024: half-width of the acceptance band around TARGET_MAG.
- STEP_FAST, 3: gain step shift in ACQUIRE (step = gain>>3).
- STEP_SLOW, 6: gain step shift in TRACK.
- LOCK_COUNT, 3: consecutive in-band windows required to enter TRACK.
- GAIN_MIN, 1024: gain floor (1/16, unsigned 4.14).
- GAIN_MAX, 262143: gain ceiling (~16.0).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sam_clk_ena  in  1  sample strobe
- sym_clk_ena  in  1  symbol strobe; always coincides with sam_clk_ena
- agc_en  in  1  1 = adapt; 0 = hold gain
- sig_in  in  18 signed 1s17  channel output
- sig_out  out  18 signed 1s17  gain-corrected sample
- gain_out  out  18 unsigned 4.14  current gain
- mag_est  out  18 unsigned  last completed window mean
- locked  out  1  high in TRACK

Behaviour:
Reset values:
- sig_out=0, gain_out=16384 (1.0), mag_est=0, locked=0.
- State=ACQUIRE; symbol counter, accumulator and in-band/out-of-band counters all 0.

Datapath:
- On a clk edge with sam_clk_ena=1: sig_out <= sat18((sig_in * {1'b0,gain}) >>> 14).
- Product is 37-bit signed; saturate to [-131072, 131071].
- Latency is one enabled sample; sig_out holds between strobes.

Measurement:
- On sym_clk_ena: abs = |sig_out| using the registered value before the same-edge update; |-131072| saturates to 131071.
- acc += abs; acc is 18+WINDOW_LOG2 bits and cannot overflow.
- Symbol counter counts 0..2^WINDOW_LOG2-1.
- On the strobe where the counter = max (window end): mean = (acc+abs)>>WINDOW_LOG2; mag_est <= mean; acc <= 0; counter wraps to 0.

Gain update (window end, agc_en=1 only):
- step = gain>>STEP_FAST in ACQUIRE, gain>>STEP_SLOW in TRACK.
- mean > TARGET_MAG+DEADBAND: gain -= step.
- mean < TARGET_MAG-DEADBAND: gain += step.
- Otherwise in-band: gain unchanged.
- Result is clamped to [GAIN_MIN, GAIN_MAX] and takes effect from the next sam_clk_ena.

State machine:
- ACQUIRE: count consecutive in-band windows; an out-of-band window clears the count. Reaching LOCK_COUNT moves to TRACK, locked=1 on the same edge.
- TRACK: count consecutive out-of-band windows; an in-band window clears the count. Two consecutive out-of-band windows move to ACQUIRE, locked=0, both counts cleared.

agc_en=0:
- Gain frozen and state forced to ACQUIRE; locked=0 and lock counts cleared.
- Measurement and mag_est continue to update.
- A rising edge of agc_en does not reset the window.

Reset mid-window:
- Everything returns to reset values immediately (asynchronous).
- The first window after reset release is a full 2^WINDOW_LOG2 symbols.

Decomposition:
Shared package (agc_pkg) holds:
- the state enum {ACQUIRE, TRACK};
- the gain format constants GAIN_FRAC=14 and GAIN_ONE=16384;
- a sat18 function, also reusable by the channel and the matched filter.

One sub-module, agc_mag_meter, contains abs, the accumulator, the symbol counter, and the mean/window_done output. The gain multiply and the control FSM stay in the top level.

Test Plan:
1. Reset is asserted mid-stream -> all outputs take their reset values immediately. After release and a full window of sig_in=+32768 constant, mag_est=32768 and gain_out stays 16384.
2. Symbols alternate ±16384 with WINDOW_LOG2=4 -> first window mag_est=16384, gain_out 16384→18432. Gain keeps rising until mean is within 32768±1024. locked=1 after 3 in-band windows.
3. sig_in=-131072 constant -> abs saturates, mag_est=131071, gain_out 16384→14336 after the first window. sig_out never exceeds 18-bit range.
4. Gain is driven down with a large input until gain_out=1024 -> subsequent windows hold at 1024 (floor clamp). The mirror case with sig_in=±64 clamps at 262143.
5. In TRACK, the input amplitude is stepped ×4 -> one out-of-band window keeps locked=1 with a slow step (gain>>6). The second consecutive window drops locked and the next step uses gain>>3.
6. agc_en=0 with an off-target input -> gain_out is constant and mag_est updates each window. Re-enabling applies a correction at the next window end.
